io_port_bank: RTL
=================

# io_port_bank

Parametrised memory-mapped I/O port bank for the J1 I/O bus. It replaces hand-coded LED/HEX output registers and raw KEY/SW reads with:
- N_OUT output registers supporting write/set/clear/toggle access;
- N_IN debounced input channels, each with sticky rising-edge event latches;
- a maskable interrupt output.

The block sits between the J1 `io_*` bus and board pins. The top level ORs `io_din` across peripherals.

## Interface
- BASE_ADDR, 16'h4000: byte base address, 256-byte window; low byte is the offset.
- N_OUT, 6: output channels, 1..16.
- OUT_W, 10: output channel width, 1..16.
- OUT_INIT, 0: reset value of every output channel.
- N_IN, 2: input channels, 1..16.
- IN_W, 10: input channel width, 1..16.
- DB_CYCLES, 24000: debounce stability count, ≥1.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- io_addr  in  16  bus byte address.
- io_dout  in  16  CPU write data.
- io_wr  in  1  write strobe, one cycle per access.
- io_rd  in  1  read strobe.
- io_din  out  16  read data, combinational; 0 unless io_rd and hit.
- hit  out  1  combinational: io_addr decodes to a valid register.
- out_bus  out  N_OUT*OUT_W  channel i at [i*OUT_W +: OUT_W].
- in_bus  in  N_IN*IN_W  asynchronous pins; channel j at [j*IN_W +: IN_W].
- irq  out  1  registered interrupt request.

## Operation
- Decode uses offset = io_addr − BASE_ADDR. io_addr[0] is ignored. Index k = offset[4:1].

Register map by offset:
- 0x00+2k: OUT[k]. Read returns OUT[k]; write loads io_dout[OUT_W-1:0].
- 0x20+2k: SET[k]. Write does OUT[k] |= data; read returns OUT[k].
- 0x40+2k: CLR[k]. Write does OUT[k] &= ~data; read returns OUT[k].
- 0x60+2k: TOG[k]. Write does OUT[k] ^= data; read returns OUT[k].
- 0x80+2k: IN[k], read-only debounced value. Writes are ignored.
- 0xA0+2k: EVT[k], sticky rising-edge bits. Read returns them; write clears the bits set in data (write-1-to-clear).
- 0xC0: IEN, N_IN bits. Bit j enables the interrupt for channel j.

Address and width rules:
- An index k ≥ N_OUT (output regions) or k ≥ N_IN (input regions) is not a hit. Such reads return 0 and writes are ignored. Unlisted offsets behave the same way.
- All reads are zero-extended to 16 bits. Write data above the target width is discarded.

Input path, per channel j:
- Each bit passes through a 2-flop synchronizer (`sync`).
- samp holds the previous value of `sync`.
- A counter cnt of width $clog2(DB_CYCLES) runs per channel, not per bit. Each cycle:
  - if sync ≠ samp, cnt←0;
  - else if sync ≠ deb and cnt = DB_CYCLES−1, deb←sync and cnt←0;
  - else if sync ≠ deb, cnt←cnt+1;
  - else cnt←0.
- EVT[j] |= deb_next & ~deb (per-bit rising edge of deb).

Simultaneous events and interrupt:
- When a W1C write and a new edge hit the same EVT bit in the same cycle, set wins.
- irq ← OR over j of (IEN[j] & |EVT_next[j]). irq deasserts one cycle after the last enabled pending bit is cleared, or after IEN is cleared.

Reset values:
- OUT = OUT_INIT; deb, sync, samp, cnt, EVT, IEN = 0; irq = 0.
- Because sync and deb reset to 0, an input held high through reset produces a rising event once debounced. This is intended.
- Reset mid-debounce discards the count.

## Timing
- Output writes: OUT[k] and out_bus update at the clk edge where io_wr is sampled, i.e. visible the cycle after the write.
- Reads: io_din and hit are combinational in the same cycle.
- A read in the same cycle as a write returns the pre-write value.
- Input latency: an input change held stable is visible in IN and EVT DB_CYCLES+3 edges after the pin changes before edge 0. With DB_CYCLES=4, it is visible after edge 6.
- A glitch shorter than DB_CYCLES+1 cycles never reaches deb.
- irq asserts at the same edge as the EVT set.
- The bus is single-access per cycle, so there are no write conflicts between output registers.

## Test plan
- Reset with OUT_INIT=10'h155 → out_bus channels all 0x155, irq=0, and a read of IN[0] returns 0.
- Write 0x0F0 to 0x4000, then SET 0x00F at 0x4020, CLR 0x030 at 0x4040, TOG 0x101 at 0x4060 → OUT[0] = 0x0FF, 0x0CF, 0x1CE in turn. A read of 0x4000 returns 0x01CE.
- DB_CYCLES=4: drive in_bus ch0 bit3 high with pulses of 3 cycles → IN[0] stays 0. Hold it high → IN[0]=0x008 and EVT[0]=0x008 after edge 6.
- IEN=1 with EVT[0]=0x008 → irq=1. Write 0x008 to 0xA0 → EVT=0 and irq=0 the next cycle.
- A W1C write on the same cycle as a new rising edge of that bit → bit remains 1 and irq stays 1.
- Out-of-range access at offset 0x0C (k=6, N_OUT=6) and offset 0xE0 → hit=0, io_din=0, and no register changes.

Source files
------------

// File: rtl/io_port_bank.sv
// Memory-mapped I/O port bank: write/set/clear/toggle output registers,
// debounced inputs with sticky rising-edge events, and a maskable irq.
module io_port_bank #(
  parameter logic [15:0]      BASE_ADDR = 16'h4000,
  parameter int               N_OUT     = 6,
  parameter int               OUT_W     = 10,
  parameter logic [OUT_W-1:0] OUT_INIT  = '0,
  parameter int               N_IN      = 2,
  parameter int               IN_W      = 10,
  parameter int               DB_CYCLES = 24000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            io_addr,
  input  logic [15:0]            io_dout,
  input  logic                   io_wr,
  input  logic                   io_rd,
  output logic [15:0]            io_din,
  output logic                   hit,
  output logic [N_OUT*OUT_W-1:0] out_bus,
  input  logic [N_IN*IN_W-1:0]   in_bus,
  output logic                   irq
);

  localparam int              CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [4:0]      N_OUT_L = 5'(N_OUT);
  localparam logic [4:0]      N_IN_L  = 5'(N_IN);

  logic [15:0] offset;
  logic [2:0]  region;
  logic [3:0]  idx;
  logic        in_win;
  logic        wr_hit;
  logic [15:0] rdata;

  logic [OUT_W-1:0] out_q [N_OUT];
  logic [OUT_W-1:0] out_d [N_OUT];
  logic [IN_W-1:0]  meta_q [N_IN];
  logic [IN_W-1:0]  sync_q [N_IN];
  logic [IN_W-1:0]  samp_q [N_IN];
  logic [IN_W-1:0]  deb_q  [N_IN];
  logic [IN_W-1:0]  deb_d  [N_IN];
  logic [IN_W-1:0]  evt_q  [N_IN];
  logic [IN_W-1:0]  evt_d  [N_IN];
  logic [CNT_W-1:0] cnt_q  [N_IN];
  logic [CNT_W-1:0] cnt_d  [N_IN];
  logic [N_IN-1:0]  ien_q, ien_d;
  logic             irq_q, irq_d;

  logic [OUT_W-1:0] wdat_out;
  logic [IN_W-1:0]  wdat_in;

  // offset[0] is the ignored byte lane; upper io_dout bits are discarded by width
  logic unused_ok;
  assign unused_ok = ^{offset[0], io_dout};

  assign offset   = io_addr - BASE_ADDR;
  assign in_win   = (offset[15:8] == 8'h00);
  assign region   = offset[7:5];
  assign idx      = offset[4:1];
  assign wdat_out = io_dout[OUT_W-1:0];
  assign wdat_in  = io_dout[IN_W-1:0];
  assign wr_hit   = io_wr && hit;

  always_comb begin
    hit = 1'b0;
    if (in_win) begin
      case (region)
        3'd0, 3'd1, 3'd2, 3'd3: hit = ({1'b0, idx} < N_OUT_L);
        3'd4, 3'd5:             hit = ({1'b0, idx} < N_IN_L);
        3'd6:                   hit = (idx == 4'd0);
        default:                hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (region <= 3'd3) begin
      for (int i = 0; i < N_OUT; i++)
        if (idx == 4'(i)) rdata = 16'(out_q[i]);
    end else if (region == 3'd4) begin
      for (int j = 0; j < N_IN; j++)
        if (idx == 4'(j)) rdata = 16'(deb_q[j]);
    end else if (region == 3'd5) begin
      for (int j = 0; j < N_IN; j++)
        if (idx == 4'(j)) rdata = 16'(evt_q[j]);
    end else if (region == 3'd6) begin
      rdata = 16'(ien_q);
    end
  end

  assign io_din = (io_rd && hit) ? rdata : 16'h0000;

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      out_d[i] = out_q[i];
      if (wr_hit && idx == 4'(i)) begin
        case (region)
          3'd0:    out_d[i] = wdat_out;
          3'd1:    out_d[i] = out_q[i] | wdat_out;
          3'd2:    out_d[i] = out_q[i] & ~wdat_out;
          3'd3:    out_d[i] = out_q[i] ^ wdat_out;
          default: out_d[i] = out_q[i];
        endcase
      end
    end
  end

  // Counter is per channel: any bit moving restarts stability timing for the whole channel.
  always_comb begin
    irq_d = 1'b0;
    for (int j = 0; j < N_IN; j++) begin
      deb_d[j] = deb_q[j];
      cnt_d[j] = '0;
      if (sync_q[j] != samp_q[j]) begin
        cnt_d[j] = '0;
      end else if (sync_q[j] != deb_q[j]) begin
        if (cnt_q[j] == CNT_MAX) deb_d[j] = sync_q[j];
        else                     cnt_d[j] = cnt_q[j] + 1'b1;
      end
      evt_d[j] = evt_q[j];
      if (wr_hit && region == 3'd5 && idx == 4'(j)) evt_d[j] = evt_q[j] & ~wdat_in;
      evt_d[j] = evt_d[j] | (deb_d[j] & ~deb_q[j]);
      irq_d = irq_d | (ien_q[j] & (|evt_d[j]));
    end
  end

  assign ien_d = (wr_hit && region == 3'd6) ? io_dout[N_IN-1:0] : ien_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) out_q[i] <= OUT_INIT;
      for (int j = 0; j < N_IN; j++) begin
        meta_q[j] <= '0;
        sync_q[j] <= '0;
        samp_q[j] <= '0;
        deb_q[j]  <= '0;
        evt_q[j]  <= '0;
        cnt_q[j]  <= '0;
      end
      ien_q <= '0;
      irq_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++) out_q[i] <= out_d[i];
      for (int j = 0; j < N_IN; j++) begin
        meta_q[j] <= in_bus[j*IN_W +: IN_W];
        sync_q[j] <= meta_q[j];
        samp_q[j] <= sync_q[j];
        deb_q[j]  <= deb_d[j];
        evt_q[j]  <= evt_d[j];
        cnt_q[j]  <= cnt_d[j];
      end
      ien_q <= ien_d;
      irq_q <= irq_d;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_bus[g*OUT_W +: OUT_W] = out_q[g];
  end

  assign irq = irq_q;

endmodule
